// File: rtl/irq_pending_arbiter_if.sv
// Request/acknowledge bundle between the interrupt sources, the pending arbiter and its consumer.
// master = arbiter side, slave = source/consumer side.
interface irq_pending_arbiter_if;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic       overflow;

    modport master (
        input  req_in, mask, irq_ack,
        output irq_valid, irq_id, pending, overflow
    );

    modport slave (
        output req_in, mask, irq_ack,
        input  irq_valid, irq_id, pending, overflow
    );
endinterface

// File: rtl/irq_pending_arbiter.sv
// Edge-detecting pending register with masking and highest-index-first valid/ack presentation.
// Optional IRQ_REQ_SYNC_EN inserts a 2-flop synchroniser on req_in ahead of edge detection.
module irq_pending_arbiter (
    input  logic                   clk,
    input  logic                   rst_n,
    irq_pending_arbiter_if.master  bus
);
    localparam int N   = 8;
    localparam int IDW = 3;

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_e;

    state_e           state_q;
    logic [N-1:0]     req_prev_q;
    logic [N-1:0]     pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             irq_valid_q;
    logic [IDW-1:0]   irq_id_q;

    logic [N-1:0]     req_s;
    logic [N-1:0]     rise;
    logic [N-1:0]     clr;
    logic [N-1:0]     eligible;
    logic [IDW-1:0]   winner;

`ifdef IRQ_REQ_SYNC_EN
    logic [N-1:0]     sync1_q, sync2_q;
`endif

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
`ifdef IRQ_REQ_SYNC_EN
        req_s = sync2_q;
`else
        req_s = bus.req_in;
`endif
        rise = req_s & ~req_prev_q;

        clr = '0;
        if (state_q == PRESENT && bus.irq_ack)
            clr[irq_id_q] = 1'b1;

        // A new edge on the line being acknowledged wins over the clear.
        pending_d  = (pending_q & ~clr) | rise;
        overflow_d = overflow_q | (|(rise & pending_q & ~clr));

        eligible = pending_q & ~bus.mask;
        winner   = '0;
        for (int i = 0; i < N; i++)
            if (eligible[i]) winner = IDW'(i);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_prev_q  <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
`ifdef IRQ_REQ_SYNC_EN
            sync1_q     <= '0;
            sync2_q     <= '0;
`endif
        end else begin
`ifdef IRQ_REQ_SYNC_EN
            sync1_q     <= bus.req_in;
            sync2_q     <= sync1_q;
`endif
            req_prev_q  <= req_s;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;

            case (state_q)
                IDLE: begin
                    if (eligible != '0) begin
                        state_q     <= PRESENT;
                        irq_id_q    <= winner;
                        irq_valid_q <= 1'b1;
                    end else begin
                        irq_valid_q <= 1'b0;
                    end
                end
                PRESENT: begin
                    // The presented ID stays frozen until the consumer acknowledges it.
                    if (bus.irq_ack) begin
                        state_q     <= IDLE;
                        irq_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    irq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_valid = irq_valid_q;
    assign bus.irq_id    = irq_id_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed bench for irq_pending_arbiter (default build): vector table plus hand-written reset sequence.
module tb_irq_pending_arbiter;
    logic clk;
    logic rst_n;

    irq_pending_arbiter_if bus ();

    irq_pending_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic [7:0] exp_pending;
        logic       exp_ovf;
    } vec_t;

    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] req, input logic [7:0] msk, input logic ack);
        @(negedge clk);
        bus.req_in  = req;
        bus.mask    = msk;
        bus.irq_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name, input logic v, input logic [2:0] id,
                                 input logic [7:0] p, input logic o);
        check({name, ".valid"}, 32'(bus.irq_valid), 32'(v));
        if (v) check({name, ".id"}, 32'(bus.irq_id), 32'(id));
        check({name, ".pending"}, 32'(bus.pending), 32'(p));
        check({name, ".overflow"}, 32'(bus.overflow), 32'(o));
    endtask

    vec_t vecs[$];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n       = 1'b0;
        bus.req_in  = '0;
        bus.mask    = '0;
        bus.irq_ack = 1'b0;

        //            name        req    mask   ack  v  id  pend   ovf
        vecs.push_back('{"single0",  8'h10, 8'h00, 0, 0, 0, 8'h10, 0});
        vecs.push_back('{"single1",  8'h10, 8'h00, 0, 1, 4, 8'h10, 0});
        vecs.push_back('{"single2",  8'h10, 8'h00, 1, 0, 0, 8'h00, 0});
        vecs.push_back('{"single3",  8'h10, 8'h00, 0, 0, 0, 8'h00, 0});
        vecs.push_back('{"single4",  8'h00, 8'h00, 0, 0, 0, 8'h00, 0});
        vecs.push_back('{"prio0",    8'h85, 8'h00, 0, 0, 0, 8'h85, 0});
        vecs.push_back('{"prio1",    8'h85, 8'h00, 0, 1, 7, 8'h85, 0});
        vecs.push_back('{"prio2",    8'h85, 8'h00, 1, 0, 0, 8'h05, 0});
        vecs.push_back('{"prio3",    8'h85, 8'h00, 0, 1, 2, 8'h05, 0});
        vecs.push_back('{"prio4",    8'h85, 8'h00, 1, 0, 0, 8'h01, 0});
        vecs.push_back('{"prio5",    8'h85, 8'h00, 0, 1, 0, 8'h01, 0});
        vecs.push_back('{"prio6",    8'h85, 8'h00, 1, 0, 0, 8'h00, 0});
        vecs.push_back('{"prio7",    8'h00, 8'h00, 0, 0, 0, 8'h00, 0});
        vecs.push_back('{"mask0",    8'h81, 8'h80, 0, 0, 0, 8'h81, 0});
        vecs.push_back('{"mask1",    8'h81, 8'h80, 0, 1, 0, 8'h81, 0});
        vecs.push_back('{"mask2",    8'h81, 8'h80, 1, 0, 0, 8'h80, 0});
        vecs.push_back('{"ackidle",  8'h81, 8'h80, 1, 0, 0, 8'h80, 0});
        vecs.push_back('{"mask3",    8'h81, 8'h00, 0, 1, 7, 8'h80, 0});
        vecs.push_back('{"mask4",    8'h81, 8'h00, 1, 0, 0, 8'h00, 0});
        vecs.push_back('{"mask5",    8'h00, 8'h00, 0, 0, 0, 8'h00, 0});
        vecs.push_back('{"frozen0",  8'h08, 8'h00, 0, 0, 0, 8'h08, 0});
        vecs.push_back('{"frozen1",  8'h08, 8'h00, 0, 1, 3, 8'h08, 0});
        vecs.push_back('{"frozen2",  8'h48, 8'h08, 0, 1, 3, 8'h48, 0});
        vecs.push_back('{"frozen3",  8'h48, 8'h08, 0, 1, 3, 8'h48, 0});
        vecs.push_back('{"frozen4",  8'h48, 8'h00, 1, 0, 0, 8'h40, 0});
        vecs.push_back('{"frozen5",  8'h48, 8'h00, 0, 1, 6, 8'h40, 0});
        vecs.push_back('{"frozen6",  8'h48, 8'h00, 1, 0, 0, 8'h00, 0});
        vecs.push_back('{"frozen7",  8'h00, 8'h00, 0, 0, 0, 8'h00, 0});
        vecs.push_back('{"setwin0",  8'h04, 8'h00, 0, 0, 0, 8'h04, 0});
        vecs.push_back('{"setwin1",  8'h00, 8'h00, 0, 1, 2, 8'h04, 0});
        vecs.push_back('{"setwin2",  8'h04, 8'h00, 1, 0, 0, 8'h04, 0});
        vecs.push_back('{"setwin3",  8'h04, 8'h00, 0, 1, 2, 8'h04, 0});
        vecs.push_back('{"setwin4",  8'h04, 8'h00, 1, 0, 0, 8'h00, 0});
        vecs.push_back('{"setwin5",  8'h00, 8'h00, 0, 0, 0, 8'h00, 0});
        vecs.push_back('{"ovf0",     8'h20, 8'h00, 0, 0, 0, 8'h20, 0});
        vecs.push_back('{"ovf1",     8'h00, 8'h00, 0, 1, 5, 8'h20, 0});
        vecs.push_back('{"ovf2",     8'h20, 8'h00, 0, 1, 5, 8'h20, 1});
        vecs.push_back('{"ovf3",     8'h20, 8'h00, 1, 0, 0, 8'h00, 1});
        vecs.push_back('{"ovf4",     8'h00, 8'h00, 0, 0, 0, 8'h00, 1});

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        check("reset.id", 32'(bus.irq_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].mask, vecs[i].ack);
            check_outputs(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_id,
                          vecs[i].exp_pending, vecs[i].exp_ovf);
        end

        // Reset while presenting with every line pending.
        step(8'hFF, 8'h00, 1'b0);
        check_outputs("rstmid0", 1'b0, 3'd0, 8'hFF, 1'b1);
        step(8'hFF, 8'h00, 1'b0);
        check_outputs("rstmid1", 1'b1, 3'd7, 8'hFF, 1'b1);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.req_in  = 8'h01;
        @(posedge clk);
        #1;
        check_outputs("rstmid2", 1'b0, 3'd0, 8'h00, 1'b0);
        check("rstmid2.id", 32'(bus.irq_id), 32'd0);
        step(8'h01, 8'h00, 1'b0);
        check_outputs("rstmid3", 1'b0, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rel1", 1'b0, 3'd0, 8'h01, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rel2", 1'b1, 3'd0, 8'h01, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
